hwpe_stream_job_ctrl: RTL

Job-level sequencer for a group of HWPE source/sink streaming engines. It latches a job's engine-enable mask and issues a `req_start` handshake to each enabled engine. It then collects their `done` pulses and signals job completion, with a cycle counter and optional timeout. It sits between the HWPE control slave (register file / FSM) and the `ctrl_sourcesink_t.req_start` / `flags_sourcesink_t.{ready_start,done}` fields of each source and sink.

---
 rtl/hwpe_stream_job_ctrl_pkg.sv | 29 ++
 rtl/hwpe_stream_job_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_job_ctrl_pkg.sv
// Shared types for the HWPE stream job controller: state encoding reused from
// the source/sink engines, plus the job control/flag bundles seen by the
// control slave.
package hwpe_stream_job_ctrl_pkg;

    localparam int unsigned HWPE_STREAM_JOB_MAX_ENG = 16;
    localparam int unsigned HWPE_STREAM_JOB_CNT_W   = 16;

    typedef enum logic [1:0] {
        STREAM_IDLE    = 2'd0,
        STREAM_START   = 2'd1,
        STREAM_WORKING = 2'd2,
        STREAM_DONE    = 2'd3
    } state_sourcesink_t;

    typedef struct packed {
        logic [HWPE_STREAM_JOB_MAX_ENG-1:0] mask;
        logic [HWPE_STREAM_JOB_CNT_W-1:0]   timeout;
    } ctrl_job_t;

    typedef struct packed {
        logic                               busy;
        logic                               done;
        logic                               err;
        logic [HWPE_STREAM_JOB_MAX_ENG-1:0] done_mask;
        logic [HWPE_STREAM_JOB_CNT_W-1:0]   cycles;
    } flags_job_t;

endpackage

// File: rtl/hwpe_stream_job_ctrl.sv
// Job-level sequencer: latches an engine mask, hands out req_start to each
// enabled engine, collects their done pulses and reports job completion,
// with a saturating cycle counter and an optional timeout.
module hwpe_stream_job_ctrl
    import hwpe_stream_job_ctrl_pkg::*;
#(
    parameter int unsigned NB_ENG = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              job_start_i,
    input  logic [NB_ENG-1:0] job_mask_i,
    input  logic [CNT_W-1:0]  timeout_i,
    output logic              job_ready_o,
    output logic [NB_ENG-1:0] req_start_o,
    input  logic [NB_ENG-1:0] ready_start_i,
    input  logic [NB_ENG-1:0] eng_done_i,
    output logic              busy_o,
    output logic              job_done_o,
    output logic              job_err_o,
    output logic [NB_ENG-1:0] done_mask_o,
    output logic [CNT_W-1:0]  cycles_o,
    output state_sourcesink_t state_o
);

    state_sourcesink_t state_q;
    logic [NB_ENG-1:0] mask_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [NB_ENG-1:0] started_q;
    logic [NB_ENG-1:0] done_mask_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              job_ready_q;
    logic              busy_q;
    logic              job_done_q;
    logic              job_err_q;

    logic [NB_ENG-1:0] req_start;
    logic [NB_ENG-1:0] started_nxt;
    logic [NB_ENG-1:0] done_mask_nxt;
    logic [CNT_W:0]    cycles_inc;
    logic              timeout_hit;
    logic              all_started;
    logic              all_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Handshake, done collection and timeout decode from current registers
    always_comb begin
        req_start     = (state_q == STREAM_START) ? (mask_q & ~started_q) : '0;
        started_nxt   = started_q | (req_start & ready_start_i);
        // only engines started in an earlier cycle may report done
        done_mask_nxt = done_mask_q | (eng_done_i & mask_q & started_q);
        all_started   = &(started_nxt | ~mask_q);
        all_done      = &(done_mask_nxt | ~mask_q);
        // one extra bit so a saturated counter can never match the timeout
        cycles_inc    = {1'b0, cycles_q} + (CNT_W+1)'(1);
        timeout_hit   = (timeout_q != '0) && (cycles_inc == {1'b0, timeout_q});
    end

    // Job FSM with registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= STREAM_IDLE;
            mask_q      <= '0;
            timeout_q   <= '0;
            started_q   <= '0;
            done_mask_q <= '0;
            cycles_q    <= '0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
            job_err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q     <= STREAM_IDLE;
            mask_q      <= '0;
            timeout_q   <= '0;
            started_q   <= '0;
            done_mask_q <= '0;
            cycles_q    <= '0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
            job_err_q   <= 1'b0;
        end else begin
            case (state_q)
                STREAM_IDLE: begin
                    if (job_start_i) begin
                        state_q     <= STREAM_START;
                        mask_q      <= job_mask_i;
                        timeout_q   <= timeout_i;
                        started_q   <= '0;
                        done_mask_q <= '0;
                        cycles_q    <= '0;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                STREAM_START: begin
                    started_q   <= started_nxt;
                    done_mask_q <= done_mask_nxt;
                    cycles_q    <= sat_inc(cycles_q);
                    if (timeout_hit) begin
                        state_q    <= STREAM_DONE;
                        busy_q     <= 1'b0;
                        job_done_q <= 1'b1;
                        job_err_q  <= 1'b1;
                    end else if (all_started) begin
                        state_q <= STREAM_WORKING;
                    end
                end
                STREAM_WORKING: begin
                    done_mask_q <= done_mask_nxt;
                    cycles_q    <= sat_inc(cycles_q);
                    if (timeout_hit) begin
                        state_q    <= STREAM_DONE;
                        busy_q     <= 1'b0;
                        job_done_q <= 1'b1;
                        job_err_q  <= 1'b1;
                    end else if (all_done) begin
                        state_q    <= STREAM_DONE;
                        busy_q     <= 1'b0;
                        job_done_q <= 1'b1;
                        job_err_q  <= 1'b0;
                    end
                end
                STREAM_DONE: begin
                    state_q     <= STREAM_IDLE;
                    job_ready_q <= 1'b1;
                    job_done_q  <= 1'b0;
                    job_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= STREAM_IDLE;
                    job_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    job_done_q  <= 1'b0;
                    job_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_start_o = req_start;
    assign job_ready_o = job_ready_q;
    assign busy_o      = busy_q;
    assign job_done_o  = job_done_q;
    assign job_err_o   = job_err_q;
    assign done_mask_o = done_mask_q;
    assign cycles_o    = cycles_q;
    assign state_o     = state_q;

endmodule
